vshift_sequencer: RTL

- Multi-cycle front end for the vector shift datapath. Accepts one whole-register vector shift operation (vsll/vsrl/vsra, .vv or .vx).
- Walks the active elements one per cycle and drives the combinational ELEN-wide element shifter placed directly downstream.
- Merges each element result back into a destination register image, applying vl, the v0 mask and tail/mask-undisturbed policy.
- Returns the completed vd through a valid/ready handshake to the vector writeback stage.

---
 rtl/vshift_sequencer.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vshift_sequencer.sv
// -----------------------------------------------------------------------------
// vshift_sequencer
//
// Multi-cycle front end for the vector shift datapath. One whole-register
// vsll/vsrl/vsra operation (.vv or .vx) is accepted, its active elements are
// walked one per cycle through the combinational element shifter sitting
// directly downstream, and each result is merged into a destination image
// honouring vl, the v0 mask and the tail/mask-undisturbed policy. The finished
// register image is returned over a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready operation request / accept (ready only while idle)
//   op, sew, vl, vm   operation, element width, active length, unmasked flag
//   use_scalar,scalar .vx form select and scalar shift amount
//   v0_mask           one mask bit per element index
//   vs2, vs1, vd_old  source elements, per-element amounts, prior destination
//   sh_*              drive to / result from the external element shifter
//   out_valid/ready   result handshake
//   vd, err           result image, reserved op/sew flag (valid with out_valid)
// -----------------------------------------------------------------------------
module vshift_sequencer #(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int SHW  = $clog2(ELEN),
  parameter int VLW  = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [1:0]        sew,
  input  logic [VLW-1:0]    vl,
  input  logic              vm,
  input  logic              use_scalar,
  input  logic [ELEN-1:0]   scalar,
  input  logic [VLEN/8-1:0] v0_mask,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vd_old,
  output logic [ELEN-1:0]   sh_src,
  output logic [SHW-1:0]    sh_shift,
  output logic              sh_left,
  output logic              sh_arith,
  output logic [ELEN-1:0]   sh_shift_in,
  input  logic [ELEN-1:0]   sh_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   vd,
  output logic              err
);

  localparam int NE   = VLEN / 8;        // max elements (e8)
  localparam int IDXW = $clog2(NE);
  localparam int BW   = $clog2(VLEN);    // bit offset width

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [1:0] SEW_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [VLW-1:0]    vl_eff_q, vl_eff_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        sew_q, sew_d;
  logic              vm_q, vm_d;
  logic              use_scalar_q, use_scalar_d;
  logic [ELEN-1:0]   scalar_q, scalar_d;
  logic [NE-1:0]     v0_mask_q, v0_mask_d;
  logic [VLEN-1:0]   vs2_q, vs2_d;
  logic [VLEN-1:0]   vs1_q, vs1_d;
  logic [VLEN-1:0]   vd_q, vd_d;
  logic              err_q, err_d;

  // ---------------------------------------------------------------------------
  // Accept-time decode: VLMAX per SEW and the clamped active length.
  // ---------------------------------------------------------------------------
  logic [VLW-1:0] vlmax_in;
  logic [VLW-1:0] vl_clamp;
  logic           illegal_in;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    vlmax_in = '0;
    case (sew)
      2'b00:   vlmax_in = VLW'(NE);
      2'b01:   vlmax_in = VLW'(NE / 2);
      2'b10:   vlmax_in = VLW'(NE / 4);
      default: vlmax_in = '0;
    endcase
    illegal_in = (op == OP_RSV) || (sew == SEW_RSV);
    vl_clamp   = (vl > vlmax_in) ? vlmax_in : vl;
  end

  // ---------------------------------------------------------------------------
  // Element selection for the current index. Elements are located by a bit
  // offset and shifted down rather than by variable part-selects, so the same
  // barrel serves all three SEW values.
  // ---------------------------------------------------------------------------
  logic [BW-1:0]   elem_base;
  logic [ELEN-1:0] elem_ones;
  logic [SHW-1:0]  amt_mask;
  logic [ELEN-1:0] src_word;
  logic [ELEN-1:0] amt_word;
  logic [ELEN-1:0] amt_src;
  logic            sign_bit;
  logic [ELEN-1:0] elem_ext;
  logic [SHW-1:0]  elem_amt;
  logic [VLEN-1:0] wr_mask;
  logic [VLEN-1:0] wr_data;
  logic            elem_active;

  always_comb begin
    elem_base = '0;
    elem_ones = '0;
    amt_mask  = '0;
    sign_bit  = 1'b0;
    src_word  = ELEN'(vs2_q >> elem_base);
    amt_word  = ELEN'(vs1_q >> elem_base);
    case (sew_q)
      2'b00: begin
        elem_base = BW'(idx_q) << 3;
        elem_ones = ELEN'(8'hFF);
        amt_mask  = SHW'(7);
      end
      2'b01: begin
        elem_base = BW'(idx_q) << 4;
        elem_ones = ELEN'(16'hFFFF);
        amt_mask  = SHW'(15);
      end
      default: begin
        elem_base = BW'(idx_q) << 5;
        elem_ones = '1;
        amt_mask  = SHW'(31);
      end
    endcase
    src_word = ELEN'(vs2_q >> elem_base);
    amt_word = ELEN'(vs1_q >> elem_base);
    case (sew_q)
      2'b00:   sign_bit = src_word[7];
      2'b01:   sign_bit = src_word[15];
      default: sign_bit = src_word[31];
    endcase

    // Sign-extend only for sra so the shifter fills with the element's sign.
    elem_ext = src_word & elem_ones;
    if ((op_q == OP_SRA) && sign_bit) elem_ext = elem_ext | ~elem_ones;

    // Amount is taken modulo SEW: only log2(SEW) bits are significant.
    amt_src  = use_scalar_q ? scalar_q : amt_word;
    elem_amt = amt_src[SHW-1:0] & amt_mask;

    wr_mask     = VLEN'(elem_ones) << elem_base;
    wr_data     = VLEN'(sh_result & elem_ones) << elem_base;
    elem_active = vm_q | v0_mask_q[idx_q];
  end

  // Shifter drive is forced to zero outside RUN.
  always_comb begin
    sh_src      = '0;
    sh_shift    = '0;
    sh_left     = 1'b0;
    sh_arith    = 1'b0;
    sh_shift_in = '0;
    if (state_q == S_RUN) begin
      sh_src   = elem_ext;
      sh_shift = elem_amt;
      sh_left  = (op_q == OP_SLL);
      sh_arith = (op_q == OP_SRA);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath update.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vl_eff_d     = vl_eff_q;
    op_d         = op_q;
    sew_d        = sew_q;
    vm_d         = vm_q;
    use_scalar_d = use_scalar_q;
    scalar_d     = scalar_q;
    v0_mask_d    = v0_mask_q;
    vs2_d        = vs2_q;
    vs1_d        = vs1_q;
    vd_d         = vd_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d         = op;
          sew_d        = sew;
          vm_d         = vm;
          use_scalar_d = use_scalar;
          scalar_d     = scalar;
          v0_mask_d    = v0_mask;
          vs2_d        = vs2;
          vs1_d        = vs1;
          vd_d         = vd_old;
          vl_eff_d     = vl_clamp;
          idx_d        = '0;
          err_d        = illegal_in;
          state_d      = (illegal_in || (vl_clamp == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Inactive (masked-off) elements keep their vd_old contents.
        if (elem_active) vd_d = (vd_q & ~wr_mask) | wr_data;
        idx_d = idx_q + IDXW'(1);
        if ((VLW'(idx_q) + VLW'(1)) == vl_eff_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: operand registers are reset too, not just control; they are
      // small and a clean reset keeps the shifter drive deterministic.
      state_q      <= S_IDLE;
      idx_q        <= '0;
      vl_eff_q     <= '0;
      op_q         <= '0;
      sew_q        <= '0;
      vm_q         <= 1'b0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      v0_mask_q    <= '0;
      vs2_q        <= '0;
      vs1_q        <= '0;
      vd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vl_eff_q     <= vl_eff_d;
      op_q         <= op_d;
      sew_q        <= sew_d;
      vm_q         <= vm_d;
      use_scalar_q <= use_scalar_d;
      scalar_q     <= scalar_d;
      v0_mask_q    <= v0_mask_d;
      vs2_q        <= vs2_d;
      vs1_q        <= vs1_d;
      vd_q         <= vd_d;
      err_q        <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign vd        = vd_q;
  assign err       = err_q;

endmodule
